// File: rtl/salu_arb_if.sv
// Request/response and salu drive signals shared between two requesters,
// the arbiter, and the salu datapath.
interface salu_arb_if #(
   parameter int WIDTH = 8
);
   logic             req0, req1;
   logic [3:0]       op0, op1;
   logic [WIDTH-1:0] a0, a1, b0, b1;
   logic             ack0, ack1;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_err;
   logic             rsp_id;
   logic [WIDTH-1:0] alu_opa, alu_opb;
   logic [3:0]       alu_mux;
   logic [WIDTH-1:0] alu_result;
   logic             busy;

   modport slave (
      input  req0, req1, op0, op1, a0, a1, b0, b1, alu_result,
      output ack0, ack1, rsp_data, rsp_err, rsp_id, alu_opa, alu_opb, alu_mux, busy
   );

   modport master (
      output req0, req1, op0, op1, a0, a1, b0, b1, alu_result,
      input  ack0, ack1, rsp_data, rsp_err, rsp_id, alu_opa, alu_opb, alu_mux, busy
   );
endinterface

// File: rtl/salu_arb.sv
// Two-requester round-robin front end for a single combinational salu:
// IDLE picks a winner and drives the salu, ISSUE lets it settle, DONE acks.
module salu_arb #(
   parameter int         WIDTH  = 8,
   parameter logic [3:0] OP_MAX = 4'hB
) (
   input logic       clk,
   input logic       rst_n,
   salu_arb_if.slave bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]       state;
   logic             winner;
   logic             last;
   logic             illegal;
   logic [WIDTH-1:0] opa_q, opb_q, data_q;
   logic [3:0]       mux_q;
   logic             err_q, id_q;

   logic             pick;
   logic [3:0]       pick_op;
   logic [WIDTH-1:0] pick_a, pick_b;

   // On a tie the requester not served last wins; a lone request always wins.
   always_comb begin
      pick    = (bus.req0 & bus.req1) ? ~last : bus.req1;
      pick_op = pick ? bus.op1 : bus.op0;
      pick_a  = pick ? bus.a1  : bus.a0;
      pick_b  = pick ? bus.b1  : bus.b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         winner  <= 1'b0;
         last    <= 1'b1;
         illegal <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         mux_q   <= 4'h0;
         data_q  <= '0;
         err_q   <= 1'b0;
         id_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req0 | bus.req1) begin
                  state   <= ISSUE;
                  winner  <= pick;
                  opa_q   <= pick_a;
                  opb_q   <= pick_b;
                  illegal <= (pick_op > OP_MAX);
                  mux_q   <= (pick_op > OP_MAX) ? 4'h0 : pick_op;
               end
            end
            ISSUE: begin
               state  <= DONE;
               data_q <= illegal ? '0 : bus.alu_result;
               err_q  <= illegal;
               id_q   <= winner;
            end
            DONE: begin
               state <= IDLE;
               last  <= winner;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Acks decode straight from state so reset kills them asynchronously.
   assign bus.ack0     = (state == DONE) & ~winner;
   assign bus.ack1     = (state == DONE) &  winner;
   assign bus.busy     = (state != IDLE);
   assign bus.rsp_data = data_q;
   assign bus.rsp_err  = err_q;
   assign bus.rsp_id   = id_q;
   assign bus.alu_opa  = opa_q;
   assign bus.alu_opb  = opb_q;
   assign bus.alu_mux  = mux_q;
endmodule
